// File: rtl/cdc_handshake_tx.sv
// Transmit side of a 4-phase req/ack clock-domain crossing: captures a word, holds it on
// data_out under req_out, and completes once the synchronized ack has risen and fallen again.
// Optional abort on a missing acknowledge: define CDC_TX_TIMEOUT_EN.
module cdc_handshake_tx #(
    parameter int DATA_W         = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    output logic              done,
    output logic              req_out,
    output logic [DATA_W-1:0] data_out,
    input  logic              ack_in,
    output logic              timeout_err
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("cdc_handshake_tx: SYNC_STAGES must be in 2..4");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("cdc_handshake_tx: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        REQ          = 2'd1,
        WAIT_ACK_LOW = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [SYNC_STAGES-1:0] ack_s;
    logic              ack_sync;
    logic              accept;
    logic              tmo_fire;
    logic              req_nxt;
    logic              done_nxt;
    logic [DATA_W-1:0] data_nxt;

    // ack_in is asynchronous; only the last stage of this chain may be consumed.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rstn) begin
            ack_s <= '0;
        end else begin
            ack_s <= {ack_s[SYNC_STAGES-2:0], ack_in};
        end
    end

    assign ack_sync  = ack_s[SYNC_STAGES-1];
    assign src_ready = rstn && (state == IDLE) && !ack_sync;
    assign accept    = src_valid && src_ready;

`ifdef CDC_TX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_hit;

    // Fires on the TIMEOUT_CYCLES-th cycle spent waiting in the current state.
    assign tmo_hit  = (state != IDLE) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign tmo_fire = tmo_hit && (((state == REQ) && !ack_sync) ||
                                  ((state == WAIT_ACK_LOW) && ack_sync));

    always_ff @(posedge clk) begin
        if (!rstn || (state_nxt != state)) begin
            tmo_cnt <= '0;
        end else if (state != IDLE) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || accept) begin
            timeout_err <= 1'b0;
        end else if (tmo_fire) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign tmo_fire    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            req_out  <= 1'b0;
            data_out <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            req_out  <= req_nxt;
            data_out <= data_nxt;
            done     <= done_nxt;
        end
    end

    always_comb begin
        // NOTE: assigning a default first keeps every path covered, so no latch is inferred.
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) state_nxt = REQ;
            end
            REQ: begin
                if (ack_sync)      state_nxt = WAIT_ACK_LOW;
                else if (tmo_fire) state_nxt = IDLE;
            end
            WAIT_ACK_LOW: begin
                if (!ack_sync || tmo_fire) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs are computed here so req_out and data_out stay glitch-free.
    always_comb begin
        req_nxt  = req_out;
        data_nxt = data_out;
        done_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    req_nxt  = 1'b1;
                    data_nxt = src_data;
                end
            end
            REQ: begin
                if (ack_sync || tmo_fire) req_nxt = 1'b0;
            end
            WAIT_ACK_LOW: begin
                req_nxt = 1'b0;
                if (!ack_sync) done_nxt = 1'b1;
            end
            default: req_nxt = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Scoreboard bench for cdc_handshake_tx: stimulus queues the word each req_out rise must carry,
// a negedge monitor checks data, stability, handshake latencies and done pulses.
module tb_cdc_handshake_tx;

    localparam int DATA_W  = 8;
    localparam int SYNC    = 2;
    localparam int TMO     = 16;

    logic              clk;
    logic              rstn;
    logic              src_valid;
    logic [DATA_W-1:0] src_data;
    logic              src_ready;
    logic              done;
    logic              req_out;
    logic [DATA_W-1:0] data_out;
    logic              ack_in;
    logic              timeout_err;

    logic resp_en;
    logic resp_ack;
    logic man_ack;
    int   resp_dly;

    assign ack_in = resp_en ? resp_ack : man_ack;

    cdc_handshake_tx #(
        .DATA_W         (DATA_W),
        .SYNC_STAGES    (SYNC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .src_valid   (src_valid),
        .src_data    (src_data),
        .src_ready   (src_ready),
        .done        (done),
        .req_out     (req_out),
        .data_out    (data_out),
        .ack_in      (ack_in),
        .timeout_err (timeout_err)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_cnt = 0;
    int last_gap = 0;
    int last_done_edge = 0;
    int ack_rise_edge  = 0;
    int ack_fall_edge  = 0;
    logic ack_prev  = 1'b0;
    logic req_prev  = 1'b0;
    logic done_prev = 1'b0;
    logic rstn_prev = 1'b0;
    logic [DATA_W-1:0] cur_word = '0;
    logic [DATA_W-1:0] exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input logic lvl, input string name);
        int n = 0;
        while (req_out !== lvl && n < 60) begin
            step();
            n++;
        end
        check(name, 32'(req_out), 32'(lvl));
    endtask

    task automatic wait_done(input int target, input string name);
        int n = 0;
        while (done_cnt < target && n < 80) begin
            step();
            n++;
        end
        check(name, done_cnt, target);
    endtask

    // Destination-side responder: raises ack resp_dly cycles after req, drops it resp_dly after req falls.
    initial begin : responder
        int rcnt;
        rcnt = 0;
        resp_ack = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (!resp_en) begin
                resp_ack = 1'b0;
                rcnt = 0;
            end else if (!resp_ack) begin
                if (!req_out) rcnt = 0;
                else if (rcnt >= resp_dly) begin resp_ack = 1'b1; rcnt = 0; end
                else rcnt++;
            end else begin
                if (req_out) rcnt = 0;
                else if (rcnt >= resp_dly) begin resp_ack = 1'b0; rcnt = 0; end
                else rcnt++;
            end
        end
    end

    // Monitor: on req_out rise pop the expected word; edges are numbered by cyc.
    always @(negedge clk) begin
        if (ack_in && !ack_prev) ack_rise_edge = cyc + 1;
        if (!ack_in && ack_prev) ack_fall_edge = cyc + 1;
        if (req_out && !req_prev) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL req_rise_unexpected: data_out=%0h with no word queued", data_out);
            end else begin
                cur_word = exp_q.pop_front();
                check("req_rise_data", 32'(data_out), 32'(cur_word));
            end
            last_gap = cyc - last_done_edge;
        end else if (req_out && req_prev) begin
            check("data_stable", 32'(data_out), 32'(cur_word));
        end
        if (!req_out && req_prev && rstn_prev && !timeout_err)
            check("req_fall_latency", cyc - ack_rise_edge, SYNC);
        if (done) begin
            done_cnt++;
            last_done_edge = cyc;
            check("done_latency", cyc - ack_fall_edge, SYNC);
            check("done_one_cycle", 32'(done_prev), 0);
            check("ready_at_done", 32'(src_ready), 1);
        end
        ack_prev  = ack_in;
        req_prev  = req_out;
        done_prev = done;
        rstn_prev = rstn;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int base;
        logic [DATA_W-1:0] b2b [3];
        b2b[0] = 8'h01;
        b2b[1] = 8'h02;
        b2b[2] = 8'h03;

        rstn = 1'b0; src_valid = 1'b0; src_data = '0;
        resp_en = 1'b0; man_ack = 1'b0; resp_dly = 3;

        // Reset state
        repeat (3) step();
        check("rst_req_out", 32'(req_out), 0);
        check("rst_data_out", 32'(data_out), 0);
        check("rst_done", 32'(done), 0);
        check("rst_src_ready", 32'(src_ready), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        rstn = 1'b1;
        step();
        check("ready_after_rst", 32'(src_ready), 1);

        // Basic transfer, responder delay 3
        resp_en = 1'b1;
        exp_q.push_back(8'hA5);
        src_valid = 1'b1; src_data = 8'hA5;
        step();
        src_valid = 1'b0;
        check("basic_req_rise", 32'(req_out), 1);
        check("basic_busy", 32'(src_ready), 0);
        wait_done(1, "basic_done");
        check("basic_ready_back", 32'(src_ready), 1);
        check("basic_data_hold", 32'(data_out), 32'h A5);

        // Data stability: 0x3C offered throughout the 0xA5 transfer
        exp_q.push_back(8'hA5);
        src_valid = 1'b1; src_data = 8'hA5;
        step();
        src_data = 8'h3C;
        exp_q.push_back(8'h3C);
        wait_done(2, "stab_first_done");
        wait_req(1'b1, "stab_second_req");
        @(negedge clk); #1;
        check("stab_accept_gap", last_gap, 1);
        src_valid = 1'b0;
        wait_done(3, "stab_second_done");
        check("stab_data_final", 32'(data_out), 32'h3C);

        // Back-to-back with an immediate responder
        resp_dly = 0;
        base = done_cnt;
        for (int k = 0; k < 3; k++) exp_q.push_back(b2b[k]);
        src_valid = 1'b1; src_data = b2b[0];
        for (int k = 0; k < 3; k++) begin
            wait_req(1'b1, "b2b_req_rise");
            @(negedge clk); #1;
            if (k > 0) check("b2b_accept_gap", last_gap, 1);
            if (k < 2) src_data = b2b[k+1];
            else src_valid = 1'b0;
            wait_req(1'b0, "b2b_req_fall");
        end
        wait_done(base + 3, "b2b_done_count");
        check("b2b_data_last", 32'(data_out), 32'h03);

        // Stale ack held through reset release
        resp_en = 1'b0; man_ack = 1'b1; rstn = 1'b0;
        repeat (3) step();
        check("stale_rst_ready", 32'(src_ready), 0);
        rstn = 1'b1;
        base = done_cnt;
        step();
        step();
        exp_q.push_back(8'h5A);
        src_valid = 1'b1; src_data = 8'h5A;
        for (int k = 0; k < 5; k++) begin
            check("stale_ready_low", 32'(src_ready), 0);
            check("stale_req_low", 32'(req_out), 0);
            step();
        end
        man_ack = 1'b0;
        step();
        check("stale_ready_d", 32'(src_ready), 0);
        step();
        check("stale_ready_d1", 32'(src_ready), 1);
        resp_dly = 2;
        resp_en = 1'b1;
        wait_req(1'b1, "stale_req_rise");
        src_valid = 1'b0;
        wait_done(base + 1, "stale_done");

        // Reset while in REQ: word lost, no done, next word completes
        resp_dly = 6;
        base = done_cnt;
        exp_q.push_back(8'h99);
        src_valid = 1'b1; src_data = 8'h99;
        step();
        src_valid = 1'b0;
        step();
        step();
        rstn = 1'b0;
        step();
        check("midrst_req_out", 32'(req_out), 0);
        check("midrst_data_out", 32'(data_out), 0);
        check("midrst_done", 32'(done), 0);
        rstn = 1'b1;
        step();
        check("midrst_ready", 32'(src_ready), 1);
        exp_q.push_back(8'h77);
        src_valid = 1'b1; src_data = 8'h77;
        wait_req(1'b1, "midrst_req_rise");
        src_valid = 1'b0;
        wait_done(base + 1, "midrst_done_count");
        check("midrst_data_final", 32'(data_out), 32'h77);

`ifdef CDC_TX_TIMEOUT_EN
        // Timeout with ack tied low
        begin
            int n;
            resp_en = 1'b0; man_ack = 1'b0;
            base = done_cnt;
            exp_q.push_back(8'hE1);
            src_valid = 1'b1; src_data = 8'hE1;
            step();
            src_valid = 1'b0;
            n = 0;
            while (req_out && n < 40) begin
                step();
                n++;
            end
            check("tmo_latency", n, TMO);
            check("tmo_err_set", 32'(timeout_err), 1);
            check("tmo_no_done", done_cnt, base);
            resp_dly = 1;
            resp_en = 1'b1;
            exp_q.push_back(8'h42);
            src_valid = 1'b1; src_data = 8'h42;
            step();
            src_valid = 1'b0;
            check("tmo_next_req", 32'(req_out), 1);
            check("tmo_err_clear", 32'(timeout_err), 0);
            wait_done(base + 1, "tmo_next_done");
        end
`endif

        repeat (4) step();
        check("final_timeout_err", 32'(timeout_err), 0);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
